// File: rtl/booth_mul_pipe_pkg.sv
// Shared types and helpers for the simd_vec_mac Booth multiplier.
// Radix-4 recoding selector and partial-product count.
package simd_vec_mac_pkg;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_sel_e;

  function automatic booth_sel_e booth_decode(
    input logic [2:0] trip
  );
    booth_sel_e sel;
    unique case (trip)
      3'b000: sel = ZERO;
      3'b001: sel = POS1;
      3'b010: sel = POS1;
      3'b011: sel = POS2;
      3'b100: sel = NEG2;
      3'b101: sel = NEG1;
      3'b110: sel = NEG1;
      3'b111: sel = ZERO;
      default: sel = ZERO;
    endcase
    return sel;
  endfunction

  function automatic int num_pp(input int w);
    return w / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_mul_pipe_if.sv
// Operand/product handshake bundle for booth_mul_pipe.
// slave = multiplier side, master = producer/consumer side.
interface booth_mul_pipe_if #(
  parameter int MULT_W = 16,
  parameter int PROD_W = 2 * MULT_W,
  parameter int TAG_W  = 4
);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [MULT_W-1:0] a_i;
  logic [MULT_W-1:0] b_i;
  logic              a_signed_i;
  logic              b_signed_i;
  logic [TAG_W-1:0]  tag_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [PROD_W-1:0] product_o;
  logic [TAG_W-1:0]  tag_o;

  modport slave (
    input  in_valid_i,
    input  a_i,
    input  b_i,
    input  a_signed_i,
    input  b_signed_i,
    input  tag_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output product_o,
    output tag_o
  );

  modport master (
    output in_valid_i,
    output a_i,
    output b_i,
    output a_signed_i,
    output b_signed_i,
    output tag_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  product_o,
    input  tag_o
  );

endinterface

// File: rtl/booth_mul_pipe_tree.sv
// Registered binary adder tree, one pipeline level per halving.
// Odd counts pass the last element through; missing leaves add zero.
module booth_pp_tree #(
  parameter int ELEM_W   = 32,
  parameter int NUM_ELEM = 9,
  parameter int SUM_W    = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en_i,
  input  logic                             valid_i,
  input  logic [NUM_ELEM-1:0][ELEM_W-1:0]  elem_i,
  output logic                             valid_o,
  output logic [SUM_W-1:0]                 sum_o
);

  localparam int LVLS = $clog2(NUM_ELEM);

  function automatic int width_at(input int l);
    int c;
    c = NUM_ELEM;
    for (int k = 0; k < l; k++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

  logic [SUM_W-1:0] node_q [LVLS][NUM_ELEM];
  logic [SUM_W-1:0] node_d [LVLS][NUM_ELEM];
  logic [LVLS-1:0]  vld_q;

  // element k of level l folds into slot k/2 of level l+1
  always_comb begin
    for (int l = 0; l < LVLS; l++) begin
      for (int j = 0; j < NUM_ELEM; j++) begin
        node_d[l][j] = '0;
      end
    end
    for (int k = 0; k < NUM_ELEM; k++) begin
      node_d[0][k/2] = node_d[0][k/2]
        + SUM_W'($signed(elem_i[k]));
    end
    for (int l = 1; l < LVLS; l++) begin
      for (int k = 0; k < NUM_ELEM; k++) begin
        if (k < width_at(l)) begin
          node_d[l][k/2] = node_d[l][k/2]
            + node_q[l-1][k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      node_q <= node_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (en_i) begin
      vld_q[0] <= valid_i;
      for (int l = 1; l < LVLS; l++) begin
        vld_q[l] <= vld_q[l-1];
      end
    end
  end

  assign valid_o = vld_q[LVLS-1];
  assign sum_o   = node_q[LVLS-1][0];

endmodule

// File: rtl/booth_mul_pipe.sv
// Pipelined radix-4 Booth multiplier with per-operand signedness,
// sideband tag and whole-pipe stall on output backpressure.
module booth_mul_pipe
  import simd_vec_mac_pkg::*;
#(
  parameter int MULT_W = 16,
  parameter int PROD_W = 2 * MULT_W,
  parameter int TAG_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_mul_pipe_if.slave bus
);

  localparam int NUM_PP   = num_pp(MULT_W);
  localparam int TREE_LVL = $clog2(NUM_PP);
  localparam int LAT      = 3 + TREE_LVL;
  localparam int TAG_DLY  = LAT - 3;
  localparam int EXT_W    = MULT_W + 2;

  logic en;
  logic out_valid_q;

  assign en             = ~out_valid_q | bus.out_ready_i;
  assign bus.in_ready_o = en;

  // stage 1: extended operands, b carries the implicit bit -1 at [0]
  logic             v1_q;
  logic [EXT_W-1:0] a1_d, a1_q;
  logic [EXT_W:0]   b1_d, b1_q;
  logic [TAG_W-1:0] t1_q;

  always_comb begin
    a1_d = {{2{bus.a_signed_i & bus.a_i[MULT_W-1]}},
            bus.a_i};
    b1_d = {{2{bus.b_signed_i & bus.b_i[MULT_W-1]}},
            bus.b_i, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
    end else if (en) begin
      v1_q <= bus.in_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      a1_q <= a1_d;
      b1_q <= b1_d;
      t1_q <= bus.tag_i;
    end
  end

  // stage 2: Booth recode and shifted partial products
  logic                           v2_q;
  logic [TAG_W-1:0]               t2_q;
  logic [PROD_W-1:0]              a_x;
  logic [PROD_W-1:0]              pp_sel;
  logic [NUM_PP-1:0][PROD_W-1:0]  pp_d, pp_q;

  always_comb begin
    a_x    = PROD_W'($signed(a1_q));
    pp_sel = '0;
    pp_d   = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      unique case (booth_decode(b1_q[2*i +: 3]))
        POS1:    pp_sel = a_x;
        POS2:    pp_sel = a_x << 1;
        NEG1:    pp_sel = -a_x;
        NEG2:    pp_sel = -(a_x << 1);
        default: pp_sel = '0;
      endcase
      pp_d[i] = pp_sel << (2 * i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_q <= 1'b0;
    end else if (en) begin
      v2_q <= v1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      pp_q <= pp_d;
      t2_q <= t1_q;
    end
  end

  // adder tree
  logic              tree_v;
  logic [PROD_W-1:0] tree_sum;

  booth_pp_tree #(
    .ELEM_W   (PROD_W),
    .NUM_ELEM (NUM_PP),
    .SUM_W    (PROD_W)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .valid_i (v2_q),
    .elem_i  (pp_q),
    .valid_o (tree_v),
    .sum_o   (tree_sum)
  );

  logic [TAG_W-1:0] tag_dly_q [TAG_DLY];

  always_ff @(posedge clk) begin
    if (en) begin
      tag_dly_q[0] <= t2_q;
      for (int k = 1; k < TAG_DLY; k++) begin
        tag_dly_q[k] <= tag_dly_q[k-1];
      end
    end
  end

  // output register
  logic [PROD_W-1:0] prod_q;
  logic [TAG_W-1:0]  tag_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      tag_q       <= '0;
    end else if (en) begin
      out_valid_q <= tree_v;
      prod_q      <= tree_sum;
      tag_q       <= tag_dly_q[TAG_DLY-1];
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.product_o   = prod_q;
  assign bus.tag_o       = tag_q;

`ifndef SYNTHESIS
  a_mult_w: assert property (
    @(posedge clk) (MULT_W % 2 == 0) && (MULT_W >= 4));

  a_in_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.in_valid_i && !bus.in_ready_o |=>
      bus.in_valid_i
      && $stable(bus.a_i) && $stable(bus.b_i)
      && $stable(bus.a_signed_i)
      && $stable(bus.b_signed_i)
      && $stable(bus.tag_i));
`endif

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Directed and streaming checks for booth_mul_pipe.
// Scoreboard pairs each accepted beat with its expected product/tag.
module tb_booth_mul_pipe;

  localparam int MW = 16;
  localparam int PW = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  booth_mul_pipe_if #(
    .MULT_W(MW), .PROD_W(PW), .TAG_W(TW)
  ) bus ();

  booth_mul_pipe #(
    .MULT_W(MW), .PROD_W(PW), .TAG_W(TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_out    = 0;

  logic [PW-1:0]    cur_exp = '0;
  logic             rnd_mode = 1'b0;
  logic [PW+TW-1:0] sb[$];
  int               out_cyc[$];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(
    input logic [MW-1:0] a, input logic [MW-1:0] b,
    input logic as, input logic bs);
    longint ea, eb;
    ea = as ? longint'($signed(a)) : longint'(a);
    eb = bs ? longint'($signed(b)) : longint'(b);
    return PW'(ea * eb);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // scoreboard: push on accept, pop and compare on consume
  initial forever begin
    logic [PW+TW-1:0] e;
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.in_valid_i && bus.in_ready_o)
        sb.push_back({cur_exp, bus.tag_i});
      if (bus.out_valid_o && bus.out_ready_i) begin
        n_out++;
        out_cyc.push_back(cyc);
        chk("sb_nonempty", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("prod", bus.product_o, e[PW+TW-1:TW]);
          chk("tag", bus.tag_o, e[TW-1:0]);
        end
      end
    end
  end

  task automatic send(input logic [MW-1:0] a,
                      input logic [MW-1:0] b,
                      input logic as, input logic bs,
                      input logic [TW-1:0] tg,
                      input logic [PW-1:0] exp,
                      output int waits);
    logic ok;
    bus.a_i        = a;
    bus.b_i        = b;
    bus.a_signed_i = as;
    bus.b_signed_i = bs;
    bus.tag_i      = tg;
    bus.in_valid_i = 1'b1;
    cur_exp        = exp;
    waits          = 0;
    ok             = 1'b0;
    while (!ok && waits < 64) begin
      @(negedge clk);
      ok = bus.in_ready_o;
      @(posedge clk);
      #1;
      if (!ok) waits++;
      if (rnd_mode)
        bus.out_ready_i = 1'($urandom_range(0, 1));
    end
    if (!ok) chk("send_accept", 64'(ok), 1);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready_i = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 0);
  endtask

  typedef struct {
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic          as;
    logic          bs;
    logic [PW-1:0] p;
  } vec_t;

  vec_t mode_v[3] = '{
    '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 32'h00000001},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'hFFFF0001}
  };

  vec_t bp_v[7] = '{
    '{16'h0002, 16'h0003, 1'b0, 1'b0, 32'h00000006},
    '{16'hFFFF, 16'h0002, 1'b1, 1'b1, 32'hFFFFFFFE},
    '{16'h0100, 16'h0100, 1'b0, 1'b0, 32'h00010000},
    '{16'h8000, 16'h0001, 1'b1, 1'b0, 32'hFFFF8000},
    '{16'h8000, 16'h0003, 1'b0, 1'b1, 32'h00018000},
    '{16'h1234, 16'h0010, 1'b0, 1'b0, 32'h00012340},
    '{16'hFFFE, 16'hFFFE, 1'b1, 1'b1, 32'h00000004}
  };

  vec_t bub_v[7] = '{
    '{16'h0000, 16'h1234, 1'b0, 1'b0, 32'h00000000},
    '{16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 32'h3FFF0001},
    '{16'h0000, 16'hFFFF, 1'b1, 1'b1, 32'h00000000},
    '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 32'h00000000},
    '{16'h7FFF, 16'h8000, 1'b1, 1'b1, 32'hC0008000},
    '{16'h0005, 16'hFFFF, 1'b0, 1'b1, 32'hFFFFFFFB},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 32'h40000000}
  };

  initial begin
    int w, wsum, n, n0, stale;
    logic [MW-1:0] ra, rb;
    logic ras, rbs;

    bus.in_valid_i  = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.a_signed_i  = 1'b0;
    bus.b_signed_i  = 1'b0;
    bus.tag_i       = '0;
    bus.out_ready_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.out_valid_o), 0);
    chk("rst_prod", 64'(bus.product_o), 0);
    chk("rst_tag", 64'(bus.tag_o), 0);
    chk("rst_ready", 64'(bus.in_ready_o), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single beat latency
    send(16'h8000, 16'h8000, 1'b1, 1'b1, 4'h5,
         32'h40000000, w);
    n = 1;
    while (!bus.out_valid_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 7);
    chk("lat_prod", 64'(bus.product_o), 64'h40000000);
    chk("lat_tag", 64'(bus.tag_o), 5);
    drain();

    for (int i = 0; i < 3; i++)
      send(mode_v[i].a, mode_v[i].b, mode_v[i].as,
           mode_v[i].bs, 4'(i + 1), mode_v[i].p, w);
    drain();

    // streaming
    n0 = n_out;
    wsum = 0;
    for (int i = 0; i < 20; i++) begin
      ra  = MW'($urandom);
      rb  = MW'($urandom);
      ras = 1'($urandom_range(0, 1));
      rbs = 1'($urandom_range(0, 1));
      send(ra, rb, ras, rbs, TW'(i),
           ref_mul(ra, rb, ras, rbs), w);
      wsum += w;
    end
    chk("stream_stall", 64'(wsum), 0);
    drain();
    chk("stream_cnt", 64'(n_out - n0), 20);
    if (out_cyc.size() >= n0 + 20)
      chk("stream_gap",
          64'(out_cyc[n0+19] - out_cyc[n0]), 19);

    // backpressure with a full pipe
    n0 = n_out;
    for (int i = 0; i < 7; i++)
      send(bp_v[i].a, bp_v[i].b, bp_v[i].as,
           bp_v[i].bs, 4'(8 + i), bp_v[i].p, w);
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ready", 64'(bus.in_ready_o), 0);
      chk("bp_valid", 64'(bus.out_valid_o), 1);
      chk("bp_prod", 64'(bus.product_o), 64'h6);
      chk("bp_tag", 64'(bus.tag_o), 8);
    end
    drain();
    chk("bp_cnt", 64'(n_out - n0), 7);

    // reset with beats in flight
    for (int i = 0; i < 4; i++)
      send(16'h0011, 16'h0022, 1'b0, 1'b0, 4'hA,
           32'h00000242, w);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid_o), 0);
    chk("mid_rst_prod", 64'(bus.product_o), 0);
    chk("mid_rst_tag", 64'(bus.tag_o), 0);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid_o) stale++;
    end
    chk("mid_rst_stale", 64'(stale), 0);
    send(16'h0003, 16'hFFFB, 1'b1, 1'b1, 4'h3,
         32'hFFFFFFF1, w);
    drain();

    // bubbles with random output readiness
    n0 = n_out;
    rnd_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(bub_v[i].a, bub_v[i].b, bub_v[i].as,
           bub_v[i].bs, 4'(i + 2), bub_v[i].p, w);
      @(posedge clk);
      #1;
      bus.out_ready_i = 1'($urandom_range(0, 1));
    end
    rnd_mode = 1'b0;
    drain();
    chk("bub_cnt", 64'(n_out - n0), 7);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
